// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, registered carry
// between stages, valid/ready handshake with a full-pipeline stall on output backpressure.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // Rank 0 is the capture register; rank k+1 holds the result of adder stage k.
    logic [STAGES:0]  v_q;
    logic [STAGES:0]  c_q;
    logic [WIDTH-1:0] a_q [0:STAGES];
    logic [WIDTH-1:0] b_q [0:STAGES];
    logic [WIDTH-1:0] s_q [0:STAGES];
    logic [CHUNK:0]   part [0:STAGES-1];
    logic             stall;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[STAGES];
    assign Sum       = s_q[STAGES];
    assign Cout      = c_q[STAGES];
    assign Ovf       = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1]) &&
                       (s_q[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]} +
                      {1'b0, b_q[k][k*CHUNK +: CHUNK]} +
                      {{CHUNK{1'b0}}, c_q[k]};
        end
    end

    // Data registers only load behind a valid entry, so a bubble leaves the output payload untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                a_q[0] <= In1;
                b_q[0] <= Sub ? ~In2 : In2;
                c_q[0] <= Sub | Cin;
            end
            for (int k = 0; k < STAGES; k++) begin
                v_q[k+1] <= v_q[k];
                if (v_q[k]) begin
                    a_q[k+1]                  <= a_q[k];
                    b_q[k+1]                  <= b_q[k];
                    c_q[k+1]                  <= part[k][CHUNK];
                    s_q[k+1]                  <= s_q[k];
                    s_q[k+1][k*CHUNK +: CHUNK] <= part[k][CHUNK-1:0];
                end
            end
        end
    end

endmodule
